// File: rtl/loop_block.sv
// Discrete-time PI loop filter: an edge-detected enable captures a residual,
// updates a clamped integrator, then scales and saturates P+I onto a held output.
module loop_block #(
    parameter logic signed [15:0] KP        = 16'sd1,
    parameter logic signed [15:0] KI        = 16'sd1,
    parameter int                 SHIFT     = 0,
    parameter int                 ACC_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic signed [15:0] res,
    output logic signed [15:0] out
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                        r_enQ;
    logic signed [15:0]          r_resQ;
    logic                        r_s1;
    logic                        r_s2;
    logic signed [31:0]          r_p;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [15:0]          r_out;

    logic                        w_event;
    logic signed [31:0]          w_pProd;
    logic signed [31:0]          w_kiProd;
    logic signed [ACC_WIDTH:0]   w_accExt;
    logic signed [ACC_WIDTH-1:0] w_accNext;
    logic signed [ACC_WIDTH+1:0] w_sum;
    logic signed [ACC_WIDTH+1:0] w_shifted;
    logic        [ACC_WIDTH+1:15] w_hi;
    logic signed [15:0]          w_outNext;

    assign w_event  = en & ~r_enQ;
    assign w_pProd  = 32'(KP) * 32'(r_resQ);
    assign w_kiProd = 32'(KI) * 32'(r_resQ);

    // One guard bit is enough to detect integrator overflow before clamping.
    assign w_accExt = {r_acc[ACC_WIDTH-1], r_acc}
                    + {{(ACC_WIDTH-31){w_kiProd[31]}}, w_kiProd};

    always_comb begin
        w_accNext = w_accExt[ACC_WIDTH-1:0];
        if (w_accExt[ACC_WIDTH] != w_accExt[ACC_WIDTH-1]) begin
            w_accNext = w_accExt[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    assign w_sum     = {{(ACC_WIDTH-30){r_p[31]}}, r_p}
                     + {{2{r_acc[ACC_WIDTH-1]}}, r_acc};
    assign w_shifted = w_sum >>> SHIFT;
    assign w_hi      = w_shifted[ACC_WIDTH+1:15];

    always_comb begin
        w_outNext = w_shifted[15:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_outNext = w_shifted[ACC_WIDTH+1] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enQ  <= 1'b0;
            r_resQ <= '0;
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_p    <= '0;
            r_acc  <= '0;
            r_out  <= '0;
        end else begin
            r_enQ <= en;
            r_s1  <= w_event;
            r_s2  <= r_s1;
            if (w_event) begin
                r_resQ <= res;
            end
            if (r_s1) begin
                r_p   <= w_pProd;
                r_acc <= w_accNext;
            end
            if (r_s2) begin
                r_out <= w_outNext;
            end
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_loop_block.sv
// Bench for loop_block: two configurations driven in parallel, checked every
// cycle against an arithmetic event model plus hand-computed literal values.
module tb_loop_block;

    logic               clk;
    logic               reset;
    logic               en;
    logic signed [15:0] res;
    logic signed [15:0] out0;
    logic signed [15:0] out1;

    int checks   = 0;
    int failures = 0;

    loop_block dut0 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .res   (res),
        .out   (out0)
    );

    loop_block #(
        .KP        (16'sd2),
        .KI        (16'sd1),
        .SHIFT     (1),
        .ACC_WIDTH (32)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .res   (res),
        .out   (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     due;
        longint v0;
        longint v1;
    } pending_t;

    longint   kpTab[2] = '{1, 2};
    longint   kiTab[2] = '{1, 1};
    int       shTab[2] = '{0, 1};
    longint   modelAcc[2];
    longint   modelOut[2];
    pending_t pending[$];
    logic     prevEn;
    int       cycle;

    function automatic longint clampRange(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Each event updates the integrator and yields an output due two edges later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            modelAcc[0] = 0;
            modelAcc[1] = 0;
            modelOut[0] = 0;
            modelOut[1] = 0;
            pending.delete();
            prevEn = 1'b0;
            cycle  = 0;
        end else begin
            pending_t item;
            cycle++;
            while (pending.size() > 0 && pending[0].due == cycle) begin
                modelOut[0] = pending[0].v0;
                modelOut[1] = pending[0].v1;
                void'(pending.pop_front());
            end
            if (en && !prevEn) begin
                longint target[2];
                for (int k = 0; k < 2; k++) begin
                    modelAcc[k] = clampRange(modelAcc[k] + kiTab[k] * longint'(res),
                                             -64'sd2147483648, 64'sd2147483647);
                    target[k] = clampRange((kpTab[k] * longint'(res) + modelAcc[k]) >>> shTab[k],
                                           -64'sd32768, 64'sd32767);
                end
                item.due = cycle + 2;
                item.v0  = target[0];
                item.v1  = target[1];
                pending.push_back(item);
            end
            prevEn = en;
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model0", out0, modelOut[0]);
        checkOutput("model1", out1, modelOut[1]);
    end

    task automatic applyStimulus(input logic signed [15:0] value, input int highCycles,
                                 input int gapCycles);
        res = value;
        en  = 1'b1;
        repeat (highCycles) @(negedge clk);
        en = 1'b0;
        repeat (gapCycles) @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        res   = '0;
        #1;
        checkOutput("resetOut0", out0, 0);
        checkOutput("resetOut1", out1, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(16'sd1, 1, 9);
        checkOutput("seq1", out0, 2);
        applyStimulus(16'sd4, 1, 9);
        checkOutput("seq2", out0, 9);
        applyStimulus(16'sd7, 1, 9);
        checkOutput("seq3", out0, 19);
        applyStimulus(16'sd9, 1, 9);
        checkOutput("seq4", out0, 30);
        applyStimulus(16'sd14, 1, 9);
        checkOutput("seq5", out0, 49);

        doReset();
        res = 16'sd4;
        en  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("holdEarly", out0, 0);
        @(negedge clk);
        checkOutput("holdUpdate", out0, 8);
        res = 16'sd100;
        repeat (5) @(negedge clk);
        checkOutput("holdStable", out0, 8);
        en = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("holdAfter", out0, 8);

        doReset();
        applyStimulus(-16'sd100, 1, 9);
        checkOutput("negOut", out0, -200);
        checkOutput("negAcc", dut0.r_acc, -100);
        checkOutput("negShift", out1, -150);
        applyStimulus(16'sd100, 1, 9);
        checkOutput("posOut", out0, 100);
        checkOutput("posAcc", dut0.r_acc, 0);

        doReset();
        applyStimulus(16'sd32767, 1, 4);
        checkOutput("satFirst", out0, 32767);
        applyStimulus(16'sd32767, 1, 1);
        applyStimulus(16'sd32767, 1, 4);
        checkOutput("satLater", out0, 32767);
        checkOutput("satAcc", dut0.r_acc, 98301);
        doReset();
        applyStimulus(-16'sd32768, 1, 4);
        checkOutput("satNeg", out0, -32768);

        doReset();
        applyStimulus(16'sd10, 1, 9);
        checkOutput("shift1", out1, 15);
        applyStimulus(16'sd10, 1, 9);
        checkOutput("shift2", out1, 20);

        doReset();
        applyStimulus(16'sd3, 1, 9);
        checkOutput("preAsync", out0, 6);
        res = 16'sd7;
        en  = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncOut0", out0, 0);
        checkOutput("asyncOut1", out1, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("asyncHold", out0, 0);
        applyStimulus(16'sd5, 1, 9);
        checkOutput("asyncNext", out0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
